// File: rtl/base_pgate.sv
`default_nettype none
// ============================================================================
// Module : base_pgate
// Packet-aware valid/ready gate. Enable changes act on packet boundaries only.
// Optional per-open packet quota is enabled by defining BASE_PGATE_QUOTA_EN.
// Rev    : 1.0
// ============================================================================
module base_pgate #(
  parameter int WIDTH  = 64,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [CWIDTH-1:0] quota,
  input  logic              i_v,
  output logic              i_r,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_e,
  output logic              o_v,
  input  logic              o_r,
  output logic [WIDTH-1:0]  o_d,
  output logic              o_e,
  output logic              open,
  output logic              busy,
  output logic [CWIDTH-1:0] pkt_cnt,
  output logic              qdone
);

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pkt_active_q, pkt_active_d;
  logic [CWIDTH-1:0] pkt_cnt_q;
  logic              w_pass;
  logic              w_xfer;
  logic              w_eop;
  logic              w_q_exh;
  logic              w_armed;
  logic              w_qdone;

  assign w_pass = (state_q != ST_CLOSED);
  assign w_xfer = i_v & i_r;
  assign w_eop  = w_xfer & i_e;

  assign o_v     = w_pass & i_v;
  assign i_r     = w_pass & o_r;
  assign o_d     = i_d;
  assign o_e     = i_e;
  assign open    = w_pass;
  assign busy    = pkt_active_q;
  assign pkt_cnt = pkt_cnt_q;
  assign qdone   = w_qdone;

  // pkt_active_d doubles as the post-transfer packet state used by the FSM
  always_comb begin
    pkt_active_d = pkt_active_q;
    if (w_xfer) begin
      pkt_active_d = ~i_e;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLOSED: begin
        if (en && w_armed) begin
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (!en || w_q_exh) begin
          state_d = pkt_active_d ? ST_DRAIN : ST_CLOSED;
        end
      end
      ST_DRAIN: begin
        if (w_eop) begin
          state_d = (en && !w_q_exh) ? ST_OPEN : ST_CLOSED;
        end else if (en && !w_q_exh) begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_CLOSED;
      pkt_active_q <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pkt_active_q <= pkt_active_d;
      if (w_eop) begin
        pkt_cnt_q <= pkt_cnt_q + CWIDTH'(1);
      end
    end
  end

`ifdef BASE_PGATE_QUOTA_EN
  logic [CWIDTH-1:0] q_cnt_q, q_cnt_d;
  logic              q_lim_q, q_lim_d;
  logic              armed_q, armed_d;
  logic              qdone_q;
  logic              w_close_exh;

  assign w_q_exh = q_lim_q & ((q_cnt_q == '0) |
                              ((q_cnt_q == CWIDTH'(1)) & w_eop));
  assign w_close_exh = w_pass & w_q_exh & (state_d == ST_CLOSED);
  assign w_armed     = armed_q;
  assign w_qdone     = qdone_q;

  always_comb begin
    q_cnt_d = q_cnt_q;
    q_lim_d = q_lim_q;
    armed_d = armed_q;
    if ((state_q == ST_CLOSED) && (state_d == ST_OPEN)) begin
      q_cnt_d = quota;
      q_lim_d = |quota;
    end else if (w_eop && q_lim_q && (q_cnt_q != '0)) begin
      q_cnt_d = q_cnt_q - CWIDTH'(1);
    end
    // A cycle with en low re-arms even if exhaustion closes in that same cycle
    if (!en) begin
      armed_d = 1'b1;
    end else if (w_close_exh) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_cnt_q <= '0;
      q_lim_q <= 1'b0;
      armed_q <= 1'b1;
      qdone_q <= 1'b0;
    end else begin
      q_cnt_q <= q_cnt_d;
      q_lim_q <= q_lim_d;
      armed_q <= armed_d;
      qdone_q <= w_close_exh;
    end
  end
`else
  logic w_unused_quota;

  assign w_unused_quota = ^quota;
  assign w_q_exh        = 1'b0;
  assign w_armed        = 1'b1;
  assign w_qdone        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_base_pgate.sv
`default_nettype none
// ============================================================================
// Module : tb_base_pgate
// Scoreboard bench for base_pgate: expected beats queued by stimulus, popped
// by an output monitor. Quota scenarios follow BASE_PGATE_QUOTA_EN.
// Rev    : 1.0
// ============================================================================
module tb_base_pgate;

  localparam int WIDTH  = 32;
  localparam int CWIDTH = 4;

  logic              clk;
  logic              rstn;
  logic              en;
  logic [CWIDTH-1:0] quota;
  logic              i_v;
  logic              i_r;
  logic [WIDTH-1:0]  i_d;
  logic              i_e;
  logic              o_v;
  logic              o_r;
  logic [WIDTH-1:0]  o_d;
  logic              o_e;
  logic              open;
  logic              busy;
  logic [CWIDTH-1:0] pkt_cnt;
  logic              qdone;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             e;
  } beat_t;

  beat_t             exp_q[$];
  int                n_vec;
  int                n_err;
  logic [CWIDTH-1:0] exp_pkt;
  logic              rnd_or;

  base_pgate #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .quota(quota),
    .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_e(i_e),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e),
    .open(open), .busy(busy), .pkt_cnt(pkt_cnt), .qdone(qdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // Output monitor: every accepted output beat must match the queue head
  always @(negedge clk) begin
    if (rstn && o_v && o_r) begin
      beat_t b;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got d=%h e=%b, required no beat", o_d, o_e);
      end else begin
        b = exp_q.pop_front();
        if (o_d !== b.d || o_e !== b.e) begin
          n_err++;
          $display("FAIL beat: got d=%h e=%b, required d=%h e=%b", o_d, o_e, b.d, b.e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until the gate accepts it (bounded wait)
  task automatic beat(input logic [WIDTH-1:0] d, input logic e);
    bit ok;
    ok  = 1'b0;
    i_v = 1'b1;
    i_d = d;
    i_e = e;
    for (int k = 0; k < 64; k++) begin
      if (rnd_or) o_r = (k > 8) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i_r) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: d=%h not accepted, required acceptance", d);
    end else begin
      @(posedge clk);
      #1;
    end
    i_v = 1'b0;
    i_e = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic e);
    beat_t b;
    b.d = d;
    b.e = e;
    exp_q.push_back(b);
    if (e) exp_pkt = exp_pkt + CWIDTH'(1);
    beat(d, e);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_pkt = '0;
    rnd_or  = 1'b0;
    rstn    = 1'b0;
    en      = 1'b0;
    quota   = '0;
    i_v     = 1'b1;
    i_d     = '0;
    i_e     = 1'b0;
    o_r     = 1'b1;
    tick();
    tick();
    check("rst_open", open, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_qdone", qdone, 0);
    check("rst_o_v", o_v, 0);
    check("rst_i_r", i_r, 0);
    i_v  = 1'b0;
    rstn = 1'b1;
    tick();

    // 3-beat packet after opening
    en = 1'b1;
    check("open_same_cycle", open, 0);
    tick();
    check("open_after_en", open, 1);
    send(32'hA000_0000, 1'b0);
    send(32'hA000_0001, 1'b0);
    send(32'hA000_0002, 1'b1);
    check("pkt_cnt_1", pkt_cnt, 1);
    check("busy_idle_1", busy, 0);

    // en falls after beat 1 of a 4-beat packet: drain to the boundary
    send(32'hB000_0000, 1'b0);
    check("busy_mid", busy, 1);
    en = 1'b0;
    send(32'hB000_0001, 1'b0);
    check("drain_open", open, 1);
    send(32'hB000_0002, 1'b0);
    send(32'hB000_0003, 1'b1);
    check("drain_closed", open, 0);
    check("drain_busy", busy, 0);
    check("pkt_cnt_2", pkt_cnt, 32'(exp_pkt));

    // Idle close with producer holding a beat
    en = 1'b1;
    tick();
    check("reopen", open, 1);
    en = 1'b0;
    tick();
    i_v = 1'b1;
    i_d = 32'hC000_0000;
    i_e = 1'b1;
    check("hold_o_v", o_v, 0);
    check("hold_i_r", i_r, 0);
    tick();
    tick();
    check("hold_o_v_late", o_v, 0);
    check("hold_pkt_cnt", pkt_cnt, 32'(exp_pkt));
    en = 1'b1;
    send(32'hC000_0000, 1'b1);
    check("resume_pkt_cnt", pkt_cnt, 32'(exp_pkt));

    // Single-beat packet in the cycle en falls
    en = 1'b0;
    send(32'hD000_0000, 1'b1);
    check("single_close", open, 0);

    // Last DRAIN beat with en re-asserted: straight back to OPEN
    en = 1'b1;
    tick();
    en = 1'b0;
    send(32'hE000_0000, 1'b0);
    en = 1'b1;
    send(32'hE000_0001, 1'b1);
    check("drain_to_open", open, 1);

`ifdef BASE_PGATE_QUOTA_EN
    en = 1'b0;
    tick();
    quota = 4'd2;
    en    = 1'b1;
    tick();
    check("quota_open", open, 1);
    send(32'hF000_0000, 1'b1);
    check("quota_qdone_lo", qdone, 0);
    send(32'hF000_0001, 1'b1);
    check("quota_closed", open, 0);
    check("quota_qdone", qdone, 1);
    i_v = 1'b1;
    i_d = 32'hF000_0002;
    i_e = 1'b1;
    tick();
    check("quota_qdone_pulse", qdone, 0);
    tick();
    tick();
    check("quota_blocked_i_r", i_r, 0);
    check("quota_blocked_open", open, 0);
    en = 1'b0;
    tick();
    en = 1'b1;
    send(32'hF000_0002, 1'b1);
    send(32'hF000_0003, 1'b1);
    check("quota2_qdone", qdone, 1);
    check("quota2_closed", open, 0);
    check("quota_pkt_cnt", pkt_cnt, 32'(exp_pkt));
    en = 1'b0;
    tick();
    quota = '0;
    en    = 1'b1;
    tick();
`else
    en = 1'b0;
    tick();
    quota = 4'd1;
    en    = 1'b1;
    tick();
    send(32'hF000_0000, 1'b1);
    send(32'hF000_0001, 1'b1);
    send(32'hF000_0002, 1'b1);
    check("noquota_open", open, 1);
    check("noquota_qdone", qdone, 0);
    check("noquota_pkt_cnt", pkt_cnt, 32'(exp_pkt));
`endif

    // Random backpressure in DRAIN, then reset mid-packet
    en = 1'b0;
    send(32'h1000_0000, 1'b0);
    rnd_or = 1'b1;
    send(32'h1000_0001, 1'b0);
    send(32'h1000_0002, 1'b0);
    rnd_or = 1'b0;
    check("rnd_drain_open", open, 1);
    check("rnd_busy", busy, 1);
    o_r = 1'b0;
    i_v = 1'b1;
    i_d = 32'h1000_0003;
    tick();
    check("rnd_no_loss", exp_q.size(), 0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_open", open, 0);
    check("arst_busy", busy, 0);
    check("arst_pkt_cnt", pkt_cnt, 0);
    check("arst_o_v", o_v, 0);
    check("arst_i_r", i_r, 0);
    check("arst_qdone", qdone, 0);
    i_v = 1'b0;
    o_r = 1'b1;
    tick();
    rstn    = 1'b1;
    exp_pkt = '0;
    tick();

    // 16 packets on a 4-bit counter wrap back to zero
    en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      send(32'h2000_0000 + 32'(i), 1'b1);
      if (i == 14) check("pkt_cnt_15", pkt_cnt, 15);
    end
    check("pkt_cnt_wrap", pkt_cnt, 0);

    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/base_pgate.md
# base_pgate

Packet-aware, parametrised successor to the single-bit valid/ready gate. Passes a valid/ready data stream with end-of-packet marker through combinationally while open. Enable changes take effect only on packet boundaries, so a packet is never truncated. An optional per-open packet quota closes the gate automatically. Sits between any streaming producer and consumer in the AFU, e.g. to quiesce a command or data path before reset or reconfiguration.

## Interface
- `width`, 64: data bus width.
- `cwidth`, 16: width of the quota and packet counters.

- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset.
- `en` in 1: gate enable request, level-sensitive.
- `quota` in cwidth: packets allowed per open. 0 means unlimited. Sampled on CLOSED->OPEN.
- `i_v` in 1: input valid.
- `i_r` out 1: input ready.
- `i_d` in width: input data.
- `i_e` in 1: input end-of-packet, qualified by `i_v`.
- `o_v` out 1: output valid.
- `o_r` in 1: output ready.
- `o_d` out width: output data, equal to `i_d` at all times.
- `o_e` out 1: output end-of-packet, equal to `i_e`.
- `open` out 1: 1 in OPEN or DRAIN.
- `busy` out 1: packet in progress (`pkt_active`).
- `pkt_cnt` out cwidth: completed packets since reset; wraps.
- `qdone` out 1: one-cycle pulse when quota exhaustion closes the gate.

## Operation
- Transfer: `xfer = i_v & i_r`.
- `pass` = state is OPEN or DRAIN.
- Datapath: `o_v = pass & i_v`; `i_r = pass & o_r`. This is pure combinational pass-through with no added latency.
- `pkt_active` register:
  - Set on `xfer & ~i_e`.
  - Cleared on `xfer & i_e`.
- `pkt_post` = value of `pkt_active` after the current cycle's transfer.
- States: CLOSED, OPEN, DRAIN.
- CLOSED -> OPEN when `en` is 1 and `armed` is 1. Load `q_cnt <= quota`.
- OPEN:
  - If `en` is 0 or `q_exh` is 1: go to DRAIN if `pkt_post` is 1, otherwise go to CLOSED.
  - Otherwise stay in OPEN.
- DRAIN:
  - On `xfer & i_e`: go to OPEN if `en` is 1 and `q_exh` is 0; otherwise go to CLOSED.
  - If `en` returns to 1 while `q_exh` is 0: go to OPEN. The packet continues uninterrupted.
- `q_exh` is combinational. It is 1 when the quota is nonzero-loaded (`q_lim` is 1) and either:
  - `q_cnt` is 0, or
  - `q_cnt` is 1 and the current cycle has `xfer & i_e`.
- `q_cnt` decrements on each `xfer & i_e` while `pass` is 1, `q_lim` is 1 and `q_cnt` is nonzero. It never underflows.
- `armed`:
  - Cleared when the gate closes due to quota exhaustion.
  - Set in any cycle with `en` at 0.
  - After exhaustion the gate stays CLOSED until `en` is deasserted for at least one cycle.
- `qdone` pulses in the cycle the state becomes CLOSED due to exhaustion.
- `pkt_cnt` increments on every `xfer & i_e` and wraps from all-ones to 0.

## Timing
- Reset values:
  - Internal: state CLOSED, `pkt_active` 0, `q_cnt` 0, `q_lim` 0, `armed` 1.
  - Outputs: `open` 0, `busy` 0, `pkt_cnt` 0, `qdone` 0, `o_v` 0, `i_r` 0.
  - Reset may assert mid-packet. The packet state is discarded and the gate returns CLOSED.
- `en` to `open` latency: 1 cycle when opening, and 1 cycle when closing at a boundary. `o_v`/`i_r` follow `open` in the same cycle.
- Closing on `en` 0 in OPEN: the gate still passes in the cycle `en` falls, because the state is registered.
  - A non-final beat transferred in that cycle sends the state to DRAIN, not CLOSED.
- Single-beat packet (`i_v`, `i_e`) in the cycle `en` falls: transferred, then CLOSED next cycle.
- DRAIN with the last beat plus `en` re-asserted in the same cycle: next state is OPEN (no bubble).
- Quota 1: the first `i_e` transfer makes `q_exh` 1 combinationally. The next state is CLOSED, and `qdone` is 1 in the first CLOSED cycle.
- `o_r` low while in DRAIN: the gate waits indefinitely. There is no timeout.
- When not passing, `i_v` is ignored and no beat is lost; the producer holds it.

## Configuration
- `BASE_PGATE_QUOTA_EN` defined: quota logic as above.
- Not defined:
  - `quota` is ignored; `q_lim`, `q_cnt` and `q_exh` are tied to 0.
  - `armed` is tied to 1 and `qdone` is tied to 0.
  - The gate is controlled by `en` alone.
  - Port list is unchanged.

## Test plan
- Reset, then `en` 1, then a 3-beat packet with `o_r` 1 -> `open` is 1 one cycle after `en`; 3 beats are passed, with `o_e` on beat 3; `pkt_cnt` is 1.
- `en` 0 after beat 1 of a 4-beat packet -> state DRAIN; beats 2-4 pass; `open` is 0 the cycle after beat 4; `busy` is 0.
- `en` 0 while idle, `i_v` 1 held -> `o_v` and `i_r` are 0 from the next cycle; no beat is consumed; `en` 1 resumes with the same beat.
- Quota 2 (`BASE_PGATE_QUOTA_EN` defined), `en` held at 1, five 1-beat packets -> exactly 2 pass; `qdone` pulses once; gate stays closed until `en` goes 0 for 1 cycle and then back to 1, after which 2 more pass.
- `o_r` toggling randomly in DRAIN, plus async `rstn` low mid-packet -> no beat is duplicated or dropped before reset; all outputs hold their reset values immediately; `busy` is 0.
- `pkt_cnt` preloaded near wrap (cwidth 4, 16 packets) -> reads 0 after the 16th packet.
